// File: rtl/uart_tx_buffered.sv
// UART transmitter with a 16x-oversampled baud divider and a transmit FIFO.
// Line-facing outputs are registered, so tx/tx_busy/tx_done_tick trail the FSM state by one cycle.
module uart_tx_buffered #(
   parameter real CLK_FREQ   = 100_000_000.0,
   parameter real BAUDRATE   = 115_200.0,
   parameter int  DATA_BITS  = 8,
   parameter int  PARITY     = 0,
   parameter int  STOP_BITS  = 1,
   parameter int  FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          tx,
   output logic                          tx_busy,
   output logic                          tx_done_tick,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int DIV_RAW = $rtoi(CLK_FREQ / (16.0 * BAUDRATE) + 0.5);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int BIT_W   = $clog2(DATA_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST        = DIV_W'(DIV - 1);
   localparam logic [4:0]       BIT_TICKS_LAST  = 5'd15;
   localparam logic [4:0]       STOP_TICKS_LAST = 5'(16 * STOP_BITS - 1);
   localparam logic [BIT_W-1:0] DATA_LAST       = BIT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] DEPTH_C         = CNT_W'(FIFO_DEPTH);

   generate
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx_buffered: DATA_BITS must be in 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
      end
      if (BAUDRATE <= 0.0 || CLK_FREQ <= 0.0) begin : g_bad_rates
         $error("uart_tx_buffered: CLK_FREQ and BAUDRATE must be positive");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // ---------------- transmit FIFO ----------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [DATA_BITS-1:0] head;
   logic                 wr_en;
   logic                 pop;

   assign tx_ready = (fifo_count != DEPTH_C);
   assign wr_en    = tx_valid && tx_ready;
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ---------------- framing FSM ----------------
   state_t               state,   state_n;
   logic [DIV_W-1:0]     div_cnt, div_n;
   logic [4:0]           tick_cnt, tick_n;
   logic [BIT_W-1:0]     bit_cnt, bit_n;
   logic [DATA_BITS-1:0] shreg,   shreg_n;
   logic                 par_bit, par_n;
   logic                 tx_n;
   logic                 busy_n;
   logic                 done_n;
   logic                 s_tick;
   logic [4:0]           tick_last;
   logic                 bit_end;

   assign s_tick    = (div_cnt == DIV_LAST);
   assign tick_last = (state == S_STOP) ? STOP_TICKS_LAST : BIT_TICKS_LAST;
   assign bit_end   = s_tick && (tick_cnt == tick_last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         div_cnt      <= '0;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         tx           <= 1'b1;
         tx_busy      <= 1'b0;
         tx_done_tick <= 1'b0;
      end else begin
         state        <= state_n;
         div_cnt      <= div_n;
         tick_cnt     <= tick_n;
         bit_cnt      <= bit_n;
         shreg        <= shreg_n;
         par_bit      <= par_n;
         tx           <= tx_n;
         tx_busy      <= busy_n;
         tx_done_tick <= done_n;
      end
   end

   // The line bit is chosen from the current state and registered, which is why
   // busy/done are also derived from the current state rather than the next one.
   always_comb begin
      state_n = state;
      div_n   = s_tick ? '0 : div_cnt + DIV_W'(1);
      tick_n  = s_tick ? (bit_end ? '0 : tick_cnt + 5'd1) : tick_cnt;
      bit_n   = bit_cnt;
      shreg_n = shreg;
      par_n   = par_bit;
      tx_n    = 1'b1;
      busy_n  = (state != S_IDLE);
      done_n  = 1'b0;
      pop     = 1'b0;
      unique case (state)
         S_IDLE: begin
            div_n  = '0;
            tick_n = '0;
            bit_n  = '0;
            if (fifo_count != '0) begin
               pop     = 1'b1;
               shreg_n = head;
               par_n   = (PARITY == 1) ? ~^head : ^head;
               state_n = S_START;
            end
         end
         S_START: begin
            tx_n = 1'b0;
            if (bit_end) begin
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            tx_n = shreg[0];
            if (bit_end) begin
               shreg_n = shreg >> 1;
               if (bit_cnt == DATA_LAST) begin
                  bit_n   = '0;
                  state_n = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_n = bit_cnt + BIT_W'(1);
               end
            end
         end
         S_PARITY: begin
            tx_n = par_bit;
            if (bit_end) begin
               state_n = S_STOP;
            end
         end
         S_STOP: begin
            tx_n = 1'b1;
            if (bit_end) begin
               done_n  = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule
